// File: rtl/svn_sgmnt_pkg.sv
// Shared constants for the seven-segment scan receiver: active-low segment
// patterns {g,f,e,d,c,b,a}, active-low digit enables and the framing states.
package svn_sgmnt_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [3:0] EN_D0    = 4'b1110;
  localparam logic [3:0] EN_D1    = 4'b1101;
  localparam logic [3:0] EN_D2    = 4'b1011;
  localparam logic [3:0] EN_D3    = 4'b0111;
  localparam logic [3:0] EN_BLANK = 4'b1111;

  typedef enum logic {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/svn_sgmnt_dec7.sv
// Combinational decode of an active-low segment pattern back to a hex nibble;
// legal is low for any pattern that is not one of the sixteen hex glyphs.
module svn_sgmnt_dec7
  import svn_sgmnt_pkg::*;
(
  input  logic [6:0] svn,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (svn)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/svn_sgmnt_rx.sv
// Seven-segment scan receiver: synchronise, wait for each digit to settle,
// decode it and reassemble digit0..digit3 into a 16-bit frame.
module svn_sgmnt_rx
  import svn_sgmnt_pkg::*;
#(
  parameter logic [15:0] SETTLE  = 16'd64,
  parameter logic [19:0] TIMEOUT = 20'd100000
) (
  input  logic        clk_16M,
  input  logic        rst_n,
  input  logic [3:0]  en,
  input  logic [6:0]  svn,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        stale
);

  logic [10:0] sync1_q, sync2_q, cap_vec_q;
  logic [15:0] settle_q;
  logic        cap_q;
  logic [19:0] to_q, to_d;
  state_e      state_q, state_d;
  logic [1:0]  expect_q, expect_d;
  logic [15:0] shadow_q, shadow_d, data_q, data_d;
  logic        acc_q, acc_d, valid_q, valid_d, ferr_q, ferr_d, stale_q, stale_d;

  logic        legal, en_ok, cap_evt, to_hit;
  logic [3:0]  nibble;
  logic [1:0]  idx;

  // sync1 is the next synced value, so a mismatch means the synced vector is changing.
  always_ff @(posedge clk_16M) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      cap_vec_q <= '1;
      settle_q  <= '0;
      cap_q     <= 1'b0;
    end else begin
      sync1_q   <= {en, svn};
      sync2_q   <= sync1_q;
      cap_vec_q <= sync2_q;
      cap_q     <= 1'b0;
      if (sync1_q != sync2_q) begin
        settle_q <= '0;
      end else if (settle_q != SETTLE) begin
        settle_q <= settle_q + 16'd1;
        cap_q    <= (settle_q == SETTLE - 16'd1);
      end
    end
  end

  svn_sgmnt_dec7 u_dec7 (
    .svn    (cap_vec_q[6:0]),
    .legal  (legal),
    .nibble (nibble)
  );

  always_comb begin
    en_ok = 1'b1;
    idx   = 2'd0;
    case (cap_vec_q[10:7])
      EN_D0:   idx   = 2'd0;
      EN_D1:   idx   = 2'd1;
      EN_D2:   idx   = 2'd2;
      EN_D3:   idx   = 2'd3;
      default: en_ok = 1'b0;
    endcase
  end

  // Blank captures neither frame data nor keep the link alive.
  assign cap_evt = cap_q && (cap_vec_q[10:7] != EN_BLANK);
  assign to_hit  = !cap_evt && (to_q == TIMEOUT - 20'd1);

  always_comb begin
    to_d      = to_q;
    stale_d   = stale_q;
    state_d   = state_q;
    expect_d  = expect_q;
    shadow_d  = shadow_q;
    acc_d     = acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;

    if (cap_evt) begin
      to_d    = '0;
      stale_d = 1'b0;
    end else if (to_q != TIMEOUT) begin
      to_d = to_q + 20'd1;
    end
    if (to_hit) begin
      stale_d = 1'b1;
    end

    if (cap_evt) begin
      if (en_ok && idx == 2'd0) begin
        shadow_d = {12'h000, nibble};
        acc_d    = !legal;
        expect_d = 2'd1;
        state_d  = COLLECT;
      end else if (state_q == COLLECT) begin
        if (en_ok && idx == expect_q) begin
          shadow_d[{expect_q, 2'b00} +: 4] = nibble;
          acc_d    = acc_q | !legal;
          expect_d = expect_q + 2'd1;
          if (expect_q == 2'd3) begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            ferr_d  = acc_d;
            state_d = SYNC;
          end
        end else begin
          shadow_d = '0;
          acc_d    = acc_q | !en_ok;
          expect_d = 2'd0;
          state_d  = SYNC;
        end
      end
    end else if (to_hit) begin
      shadow_d = '0;
      expect_d = 2'd0;
      state_d  = SYNC;
    end
  end

  always_ff @(posedge clk_16M) begin
    if (!rst_n) begin
      to_q     <= '0;
      stale_q  <= 1'b0;
      state_q  <= SYNC;
      expect_q <= 2'd0;
      shadow_q <= '0;
      acc_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      to_q     <= to_d;
      stale_q  <= stale_d;
      state_q  <= state_d;
      expect_q <= expect_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign stale      = stale_q;

endmodule
